// File: rtl/fmac_pp_reduce_seq_if.sv
// Handshake/data bundle for the folded partial-product reducer.
// The master side is the producer/consumer pair and the slave side is the reducer.
interface fmac_pp_reduce_seq_if #(
  parameter int unsigned C_WIDTH  = 23,
  parameter int unsigned C_NUM_PP = 13
);
  logic               Valid_SI;
  logic               Ready_SO;
  logic [C_WIDTH-1:0] Pp_index_DI [C_NUM_PP];
  logic               Flush_SI;
  logic               Valid_SO;
  logic               Ready_SI;
  logic [C_WIDTH-1:0] Pp_sum_DO;
  logic [C_WIDTH-1:0] Pp_carry_DO;
  logic               MSB_cor_DO;
  logic               Busy_SO;

  modport master (
    output Valid_SI, Pp_index_DI, Flush_SI, Ready_SI,
    input  Ready_SO, Valid_SO, Pp_sum_DO, Pp_carry_DO, MSB_cor_DO, Busy_SO
  );

  modport slave (
    input  Valid_SI, Pp_index_DI, Flush_SI, Ready_SI,
    output Ready_SO, Valid_SO, Pp_sum_DO, Pp_carry_DO, MSB_cor_DO, Busy_SO
  );
endinterface

// File: rtl/fmac_pp_reduce_seq.sv
// Folded Booth partial-product reducer: two chained 3:2 CSA rows consume two
// partial products per cycle and leave a carry-save (sum, carry) pair.
module fmac_pp_reduce_seq #(
  parameter int unsigned C_FMAC_MANT = 10,
  parameter int unsigned C_WIDTH     = 2*C_FMAC_MANT+3,
  parameter int unsigned C_NUM_PP    = 13
) (
  input logic                  Clk_CI,
  input logic                  Rst_RI,
  fmac_pp_reduce_seq_if.slave  bus
);

  localparam int unsigned C_STEPS = (C_NUM_PP + 1) / 2;
  localparam int unsigned C_CNT_W = $clog2(C_STEPS) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [C_CNT_W-1:0]  r_cnt;
  logic [C_WIDTH-1:0]  r_pp [C_NUM_PP];
  logic [C_WIDTH-1:0]  r_sum;
  logic [C_WIDTH-1:0]  r_carry;
  logic                r_msb;
  logic                r_valid;

  logic [C_WIDTH-1:0]  w_pad [2*C_STEPS];
  logic [C_WIDTH-1:0]  w_pp_a, w_pp_b;
  logic [C_WIDTH-1:0]  w_cfb, w_s1, w_c1, w_c1s, w_s2, w_c2;
  logic                w_ready;
  logic                w_accept;

  assign w_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & bus.Ready_SI);
  assign w_accept = bus.Valid_SI & w_ready & ~bus.Flush_SI;

  assign bus.Ready_SO    = w_ready;
  assign bus.Valid_SO    = r_valid;
  assign bus.Pp_sum_DO   = r_sum;
  assign bus.Pp_carry_DO = r_carry;
  assign bus.MSB_cor_DO  = r_msb;
  assign bus.Busy_SO     = (r_state == S_ACCUM) | (r_state == S_DONE);

  always_comb begin
    // Odd operand counts pad the last pair with a zero partial product.
    w_pad = '{default: '0};
    for (int unsigned i = 0; i < C_NUM_PP; i++) w_pad[i] = r_pp[i];
    w_pp_a = '0;
    w_pp_b = '0;
    for (int unsigned k = 0; k < C_STEPS; k++) begin
      if (r_cnt == C_CNT_W'(k)) begin
        w_pp_a = w_pad[2*k];
        w_pp_b = w_pad[2*k+1];
      end
    end
    w_cfb = {r_carry[C_WIDTH-2:0], 1'b0};
    w_s1  = r_sum ^ w_cfb ^ w_pp_a;
    w_c1  = (r_sum & w_cfb) | (r_sum & w_pp_a) | (w_cfb & w_pp_a);
    w_c1s = {w_c1[C_WIDTH-2:0], 1'b0};
    w_s2  = w_s1 ^ w_c1s ^ w_pp_b;
    w_c2  = (w_s1 & w_c1s) | (w_s1 & w_pp_b) | (w_c1s & w_pp_b);
  end

  // Priority: flush, then accept (IDLE or DONE back-to-back), then ACCUM step, then DONE drain.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pp    <= '{default: '0};
      r_sum   <= '0;
      r_carry <= '0;
      r_msb   <= 1'b0;
      r_valid <= 1'b0;
    end else if (bus.Flush_SI) begin
      if (r_state != S_IDLE) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_sum   <= '0;
        r_carry <= '0;
        r_msb   <= 1'b0;
        r_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_state <= S_ACCUM;
      r_pp    <= bus.Pp_index_DI;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_carry <= '0;
      r_msb   <= 1'b0;
      r_valid <= 1'b0;
    end else if (r_state == S_ACCUM) begin
      r_sum   <= w_s2;
      r_carry <= w_c2;
      r_msb   <= r_msb | r_carry[C_WIDTH-1] | w_c1[C_WIDTH-1];
      r_cnt   <= r_cnt + C_CNT_W'(1);
      if (r_cnt == C_CNT_W'(C_STEPS-1)) begin
        r_state <= S_DONE;
        r_valid <= 1'b1;
      end
    end else if ((r_state == S_DONE) && bus.Ready_SI) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fmac_pp_reduce_seq.sv
// Directed bench for fmac_pp_reduce_seq with 13 partial products of 23 bits.
module tb_fmac_pp_reduce_seq;

  localparam int unsigned W = 23;
  localparam int unsigned N = 13;

  logic clk;
  logic rst;
  int   n_err;
  int   n_chk;
  int   cyc;
  logic [W-1:0] s0, c0;
  logic         m0;

  fmac_pp_reduce_seq_if #(.C_WIDTH(W), .C_NUM_PP(N)) bus ();

  fmac_pp_reduce_seq #(.C_FMAC_MANT(10), .C_NUM_PP(N)) dut (
    .Clk_CI (clk),
    .Rst_RI (rst),
    .bus    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] total();
    return bus.Pp_sum_DO + {bus.Pp_carry_DO[W-2:0], 1'b0};
  endfunction

  task automatic load_const(input logic [W-1:0] v);
    for (int i = 0; i < N; i++) bus.Pp_index_DI[i] = v;
  endtask

  task automatic accept_op();
    bus.Valid_SI = 1'b1;
    tick();
    bus.Valid_SI = 1'b0;
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (bus.Valid_SO !== 1'b1 && c < 40) begin
      tick();
      c++;
    end
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    rst = 1'b1;
    bus.Valid_SI = 1'b0;
    bus.Flush_SI = 1'b0;
    bus.Ready_SI = 1'b1;
    load_const('0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.Valid_SO), 0);
    chk("rst_sum",   32'(bus.Pp_sum_DO), 0);
    chk("rst_carry", 32'(bus.Pp_carry_DO), 0);
    chk("rst_msb",   32'(bus.MSB_cor_DO), 0);
    chk("rst_busy",  32'(bus.Busy_SO), 0);
    chk("rst_ready", 32'(bus.Ready_SO), 1);
    rst = 1'b0;
    tick();

    // 1: all zero
    load_const('0);
    accept_op();
    chk("t1_busy", 32'(bus.Busy_SO), 1);
    chk("t1_ready_accum", 32'(bus.Ready_SO), 0);
    wait_valid(cyc);
    chk("t1_latency", 32'(cyc), 7);
    chk("t1_sum",   32'(bus.Pp_sum_DO), 0);
    chk("t1_carry", 32'(bus.Pp_carry_DO), 0);
    chk("t1_msb",   32'(bus.MSB_cor_DO), 0);
    tick();

    // 2: PP[i] = i+1, DONE for exactly one cycle
    for (int i = 0; i < N; i++) bus.Pp_index_DI[i] = W'(i + 1);
    accept_op();
    load_const('1);
    wait_valid(cyc);
    chk("t2_latency", 32'(cyc), 7);
    chk("t2_total", 32'(total()), 91);
    tick();
    chk("t2_valid_drop", 32'(bus.Valid_SO), 0);
    chk("t2_idle", 32'(bus.Busy_SO), 0);

    // 3: all ones
    load_const('1);
    accept_op();
    wait_valid(cyc);
    chk("t3_latency", 32'(cyc), 7);
    chk("t3_total", 32'(total()), 32'((1 << W) - 13));
    chk("t3_msb", 32'(bus.MSB_cor_DO), 1);
    tick();

    // 4: back-pressure in DONE, then back-to-back accept
    bus.Ready_SI = 1'b0;
    for (int i = 0; i < N; i++) bus.Pp_index_DI[i] = W'(1 << i);
    accept_op();
    wait_valid(cyc);
    chk("t4_latency", 32'(cyc), 7);
    chk("t4_total", 32'(total()), 8191);
    s0 = bus.Pp_sum_DO;
    c0 = bus.Pp_carry_DO;
    m0 = bus.MSB_cor_DO;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", 32'(bus.Valid_SO), 1);
      chk("t4_hold_ready", 32'(bus.Ready_SO), 0);
      chk("t4_hold_sum",   32'(bus.Pp_sum_DO), 32'(s0));
      chk("t4_hold_carry", 32'(bus.Pp_carry_DO), 32'(c0));
      chk("t4_hold_msb",   32'(bus.MSB_cor_DO), 32'(m0));
    end
    load_const(W'(100));
    bus.Ready_SI = 1'b1;
    #1;
    chk("t4_ready_comb", 32'(bus.Ready_SO), 1);
    accept_op();
    load_const(W'(12345));
    chk("t4_b2b_valid", 32'(bus.Valid_SO), 0);
    chk("t4_b2b_busy", 32'(bus.Busy_SO), 1);
    wait_valid(cyc);
    chk("t4_b2b_latency", 32'(cyc), 7);
    chk("t4_b2b_total", 32'(total()), 1300);
    tick();

    // 5: flush during the third ACCUM cycle
    load_const(W'(5));
    accept_op();
    tick();
    tick();
    bus.Flush_SI = 1'b1;
    tick();
    bus.Flush_SI = 1'b0;
    chk("t5_flush_busy",  32'(bus.Busy_SO), 0);
    chk("t5_flush_valid", 32'(bus.Valid_SO), 0);
    chk("t5_flush_ready", 32'(bus.Ready_SO), 1);
    chk("t5_flush_sum",   32'(bus.Pp_sum_DO), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_no_valid", 32'(bus.Valid_SO), 0);
    end
    load_const(W'(1));
    bus.Valid_SI = 1'b1;
    bus.Flush_SI = 1'b1;
    tick();
    bus.Flush_SI = 1'b0;
    bus.Valid_SI = 1'b0;
    chk("t5_flush_blocks_accept", 32'(bus.Busy_SO), 0);
    accept_op();
    wait_valid(cyc);
    chk("t5_latency", 32'(cyc), 7);
    chk("t5_total", 32'(total()), 13);
    tick();

    // 6: asynchronous reset mid-ACCUM
    load_const('1);
    accept_op();
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", 32'(bus.Valid_SO), 0);
    chk("t6_sum",   32'(bus.Pp_sum_DO), 0);
    chk("t6_carry", 32'(bus.Pp_carry_DO), 0);
    chk("t6_msb",   32'(bus.MSB_cor_DO), 0);
    chk("t6_busy",  32'(bus.Busy_SO), 0);
    chk("t6_ready", 32'(bus.Ready_SO), 1);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_post_idle", 32'(bus.Busy_SO), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
